// File: rtl/jtkicker_pkg.sv
// Shared types and default widths for the jtkicker object ROM path.
package jtkicker_pkg;

  localparam int unsigned OBJ_AW   = 13;
  localparam int unsigned SDRAM_AW = 22;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    LO   = 2'd2,
    HI   = 2'd3
  } objrom_st_t;

endpackage

// File: rtl/jtkicker_objrom_slot.sv
// Object ROM fetch slot: serves 32-bit renderer reads from two 16-bit SDRAM
// words, with a single-entry hit register to skip repeated fetches.
module jtkicker_objrom_slot
  import jtkicker_pkg::*;
#(
  parameter int unsigned AW     = OBJ_AW,
  parameter int unsigned SDW    = SDRAM_AW,
  parameter int unsigned OFFSET = 0
) (
  input  logic           rst,
  input  logic           clk,
  input  logic [AW-1:0]  rom_addr,
  input  logic           rom_cs,
  output logic           rom_ok,
  output logic [31:0]    rom_data,
  output logic [SDW-1:0] sdram_addr,
  output logic           sdram_req,
  input  logic           sdram_ack,
  input  logic           data_rdy,
  input  logic [15:0]    sdram_din
);

  objrom_st_t    st_q, st_d;
  logic [AW-1:0] cache_addr_q, cache_addr_d;
  logic          cache_ok_q, cache_ok_d;
  logic [AW-1:0] fetch_addr_q, fetch_addr_d;
  logic [31:0]   rom_data_q, rom_data_d;
  logic          req_q, req_d;
  logic          hit;

  assign hit        = cache_ok_q && (cache_addr_q == rom_addr);
  assign rom_ok     = rom_cs && hit;
  assign rom_data   = rom_data_q;
  assign sdram_req  = req_q;
  // Each 32-bit client word spans two SDRAM words; overflow wraps silently.
  assign sdram_addr = SDW'(OFFSET) + SDW'({fetch_addr_q, 1'b0});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q         <= IDLE;
      cache_addr_q <= '0;
      cache_ok_q   <= 1'b0;
      fetch_addr_q <= '0;
      rom_data_q   <= '0;
      req_q        <= 1'b0;
    end else begin
      st_q         <= st_d;
      cache_addr_q <= cache_addr_d;
      cache_ok_q   <= cache_ok_d;
      fetch_addr_q <= fetch_addr_d;
      rom_data_q   <= rom_data_d;
      req_q        <= req_d;
    end
  end

  always_comb begin
    st_d         = st_q;
    cache_addr_d = cache_addr_q;
    cache_ok_d   = cache_ok_q;
    fetch_addr_d = fetch_addr_q;
    rom_data_d   = rom_data_q;
    req_d        = req_q;
    case (st_q)
      IDLE: begin
        if (rom_cs && !hit) begin
          fetch_addr_d = rom_addr;
          cache_ok_d   = 1'b0;
          req_d        = 1'b1;
          st_d         = REQ;
        end
      end
      REQ: begin
        if (sdram_ack) begin
          req_d = 1'b0;
          st_d  = LO;
        end
      end
      LO: begin
        if (data_rdy) begin
          rom_data_d[15:0] = sdram_din;
          st_d             = HI;
        end
      end
      HI: begin
        // Only validate the entry if the client still wants this address.
        if (data_rdy) begin
          rom_data_d[31:16] = sdram_din;
          cache_addr_d      = fetch_addr_q;
          cache_ok_d        = (rom_addr == fetch_addr_q);
          st_d              = IDLE;
        end
      end
      default: st_d = IDLE;
    endcase
  end

endmodule
